// File: rtl/alu_64_bit.sv
// Registered 64-bit integer ALU: arithmetic, logic, shift and compare operations
// with a one-cycle latency, a zero flag and a signed-overflow flag.
module alu_64_bit (
    output logic [63:0] ALU_result,
    output logic        zero,
    output logic        overflow,
    input  logic [3:0]  ALU_CO,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        clk,
    input  logic        reset
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_NOR  = 4'b1100
    } aluOp_t;

    logic [63:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        overflow_d, overflow_q;
    logic [63:0] sum;
    logic [63:0] diff;
    logic [5:0]  shamt;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[5:0];

    // Next-state result and flags; zero is derived from the same value being registered.
    always_comb begin
        result_d   = 64'd0;
        overflow_d = 1'b0;
        case (ALU_CO)
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_ADD: begin
                result_d   = sum;
                overflow_d = (A[63] == B[63]) && (sum[63] != A[63]);
            end
            OP_XOR:  result_d = A ^ B;
            OP_SLL:  result_d = A << shamt;
            OP_SRL:  result_d = A >> shamt;
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (A[63] != B[63]) && (diff[63] != A[63]);
            end
            OP_SLT:  result_d = {63'd0, ($signed(A) < $signed(B))};
            OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
            OP_SLTU: result_d = {63'd0, (A < B)};
            OP_NOR:  result_d = ~(A | B);
            default: begin
                result_d   = 64'd0;
                overflow_d = 1'b0;
            end
        endcase
        zero_d = (result_d == 64'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= 64'd0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign ALU_result = result_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_64_bit.sv
// Directed self-checking bench for alu_64_bit: reset behaviour, arithmetic with
// overflow, compares, logic, shifts and unused opcodes.
module tb_alu_64_bit;

    logic [63:0] ALU_result;
    logic        zero;
    logic        overflow;
    logic [3:0]  ALU_CO;
    logic [63:0] A;
    logic [63:0] B;
    logic        clk;
    logic        reset;

    int testsRun;
    int testsFailed;

    alu_64_bit dut (
        .ALU_result (ALU_result),
        .zero       (zero),
        .overflow   (overflow),
        .ALU_CO     (ALU_CO),
        .A          (A),
        .B          (B),
        .clk        (clk),
        .reset      (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Drive one operation, let it be captured, then sample just after the edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
        ALU_CO = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [63:0] expResult,
                            input logic expZero, input logic expOverflow);
        checkOutput({tag, ".result"}, ALU_result, expResult);
        checkOutput({tag, ".zero"}, {63'd0, zero}, {63'd0, expZero});
        checkOutput({tag, ".ovf"}, {63'd0, overflow}, {63'd0, expOverflow});
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        ALU_CO      = 4'b0000;
        A           = 64'd0;
        B           = 64'd0;
        reset       = 1'b1;
        #1;
        checkAll("resetInit", 64'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkAll("resetHeld", 64'd0, 1'b1, 1'b0);
        reset = 1'b0;

        applyStimulus(4'b0010, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC);
        checkAll("addrAdd", 64'd1, 1'b0, 1'b0);

        applyStimulus(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        checkAll("addOvf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Inputs changing between edges must not disturb the registered outputs.
        ALU_CO = 4'b0000;
        A      = 64'd0;
        B      = 64'd0;
        #2;
        checkAll("holdBetweenEdges", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        reset = 1'b1;
        #1;
        checkAll("asyncReset", 64'd0, 1'b1, 1'b0);
        #3;
        reset = 1'b0;

        applyStimulus(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
        checkAll("subOvf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

        applyStimulus(4'b0110, 64'd7, 64'd7);
        checkAll("subZero", 64'd0, 1'b1, 1'b0);

        applyStimulus(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        checkAll("addNegNoOvf", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        applyStimulus(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        checkAll("sltNeg", 64'd1, 1'b0, 1'b0);

        applyStimulus(4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkAll("sltPos", 64'd0, 1'b1, 1'b0);

        applyStimulus(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        checkAll("sltuBig", 64'd0, 1'b1, 1'b0);

        applyStimulus(4'b1001, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkAll("sltuSmall", 64'd1, 1'b0, 1'b0);

        applyStimulus(4'b0000, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_00FF);
        checkAll("and", 64'h0000_0000_0000_00F0, 1'b0, 1'b0);

        applyStimulus(4'b0001, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_00FF);
        checkAll("or", 64'h0000_0000_0000_F0FF, 1'b0, 1'b0);

        applyStimulus(4'b0011, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_00FF);
        checkAll("xor", 64'h0000_0000_0000_F00F, 1'b0, 1'b0);

        applyStimulus(4'b1100, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_00FF);
        checkAll("nor", 64'hFFFF_FFFF_FFFF_0F00, 1'b0, 1'b0);

        applyStimulus(4'b0100, 64'h0000_0000_0000_F0F0, 64'hFFFF_FFFF_FFFF_FFC4);
        checkAll("sll", 64'h0000_0000_000F_0F00, 1'b0, 1'b0);

        applyStimulus(4'b0101, 64'h8000_0000_0000_F0F0, 64'h0000_0000_0000_0044);
        checkAll("srl", 64'h0800_0000_0000_0F0F, 1'b0, 1'b0);

        applyStimulus(4'b1000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0043);
        checkAll("sra", 64'hF000_0000_0000_0000, 1'b0, 1'b0);

        applyStimulus(4'b1000, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_003E);
        checkAll("sraPos", 64'd1, 1'b0, 1'b0);

        applyStimulus(4'b0100, 64'd1, 64'h0000_0000_0000_003F);
        checkAll("sllMax", 64'h8000_0000_0000_0000, 1'b0, 1'b0);

        applyStimulus(4'b1111, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_00FF);
        checkAll("unused1111", 64'd0, 1'b1, 1'b0);

        applyStimulus(4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        checkAll("unused1010", 64'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_64_bit.md
# alu_64_bit

Registered 64-bit integer ALU for the load/store datapath. It computes the address for loads and stores (base register plus sign-extended offset) and also provides the general arithmetic, logic, shift and compare operations. Outputs are captured in a register on each rising clock edge. The result, zero flag and signed-overflow flag drive the memory address path and branch logic.

## Interface
Parameters: none. Width is fixed at 64 bits.

Clock and reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.

Ports, in positional order: `ALU_result, zero, overflow, ALU_CO, A, B, clk, reset`. The first six positions match the existing datapath instantiation.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high; clears all outputs
- `ALU_result`  output  64  registered operation result
- `zero`  output  1  registered; 1 when the registered `ALU_result` equals 0
- `overflow`  output  1  registered; signed overflow of ADD/SUB, otherwise 0
- `ALU_CO`  input  4  operation select
- `A`  input  64  operand A (register read data 1)
- `B`  input  64  operand B (register data or sign-extended offset)

## Operation
Operation decode by `ALU_CO`:
- 0000 AND: A & B
- 0001 OR: A | B
- 0010 ADD: A + B, modulo 2^64
- 0011 XOR: A ^ B
- 0100 SLL: A << B[5:0]
- 0101 SRL: logical A >> B[5:0]
- 0110 SUB: A − B, modulo 2^64
- 0111 SLT: 1 if signed(A) < signed(B), else 0; zero-extended to 64 bits
- 1000 SRA: arithmetic A >>> B[5:0]
- 1001 SLTU: 1 if unsigned(A) < unsigned(B), else 0
- 1100 NOR: ~(A | B)
- All other codes: result 0, overflow 0

Arithmetic and flag rules:
- ADD overflow = (A[63] == B[63]) && (sum[63] != A[63]).
- SUB overflow = (A[63] != B[63]) && (diff[63] != A[63]).
- Carry out is discarded; results always wrap.
- Shift amount is `B[5:0]` only; `B[63:6]` is ignored.
- `zero` is computed from the same next-state result that is being registered, so it always agrees with the registered `ALU_result`.
- Operands are treated as unsigned except in SLT, SRA and the overflow calculation.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- There is no enable and no handshake. The outputs update on every clock edge.
- While `reset` is high, independent of `clk`: `ALU_result` = 0, `zero` = 1, `overflow` = 0.
- Reset is asynchronous. Asserting it mid-stream clears the outputs immediately, and the pending result is lost.
- After `reset` deasserts, the first rising edge captures the current inputs.
- Input changes between edges have no effect on the outputs.

## Test plan
- Reset: assert `reset` while outputs are nonzero. Required: immediately, without waiting for a clock edge, `ALU_result` = 0, `zero` = 1, `overflow` = 0.
- Address add: ALU_CO = 0010, A = 5, B = 0xFFFF_FFFF_FFFF_FFFC (−4, sign-extended offset). Required: one edge later `ALU_result` = 1, `zero` = 0, `overflow` = 0.
- Overflow: ALU_CO = 0010, A = 0x7FFF_FFFF_FFFF_FFFF, B = 1. Required: `ALU_result` = 0x8000_0000_0000_0000, `overflow` = 1.
- Overflow: ALU_CO = 0110, A = 0x8000_0000_0000_0000, B = 1. Required: `ALU_result` = 0x7FFF_FFFF_FFFF_FFFF, `overflow` = 1.
- Zero flag and compares, with A = 7, B = 7:
  - ALU_CO = 0110 gives `ALU_result` = 0, `zero` = 1.
  - SLT with A = −1, B = 1 gives 1.
  - SLTU with A = −1, B = 1 gives 0 and `zero` = 1.
- Logic and shifts, with A = 0xF0F0, B = 0x00FF:
  - AND = 0x00F0, OR = 0xF0FF, XOR = 0xF00F, NOR = 0xFFFF_FFFF_FFFF_0F00.
  - SRA with A = 0x8000_0000_0000_0000, B = 0x43 (shift amount 3) gives 0xF000_0000_0000_0000.
  - Unused code 1111 gives result 0.
